pll_ctrl: RTL and testbench

Sequencer for the iCE40UP PLL core. It runs on the PLL reference clock and drives the PLL's active-low reset, bypass and 8-bit dynamic delay inputs. It waits for a qualified, stable lock before declaring the generated clock usable, and retries on timeout or lock loss. After a bounded number of retries it falls back to bypass. It sits between the SoM top-level reset/enable logic and the PLL instance.

---
 rtl/pll_ctrl_pkg.sv | 31 +++
 rtl/pll_lock_sync.sv | 28 ++
 rtl/pll_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pll_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared types and sizing helpers for the iCE40UP PLL sequencer.
// The optional dynamic-delay feature is selected with PLL_CTRL_DYNDELAY_EN.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_FAULT     = 3'd6
    } pll_ctrl_state_t;

    // Flop count of every asynchronous-status synchronizer.
    localparam int SYNC_STAGES = 2;

    // Width of the retry counter (MAX_RETRIES is at most 7).
    localparam int RETRY_W = 3;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) return 1;
        return $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: multi-flop synchronizer for an asynchronous status input.
// Cleared by the asynchronous active-high reset so a stale lock is never seen.
module pll_lock_sync
    import pll_ctrl_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_ctrl.sv
// pll_ctrl: bring-up sequencer for the iCE40UP PLL (reset, lock qualification,
// bounded retries, bypass fallback). Define PLL_CTRL_DYNDELAY_EN to include the
// DYNAMICDELAY update handshake and the SETTLE state.
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int         RESET_CYCLES        = 16,
    parameter int         LOCK_STABLE_CYCLES  = 1024,
    parameter int         LOCK_TIMEOUT_CYCLES = 65536,
    parameter int         MAX_RETRIES         = 3,
    parameter logic [7:0] DELAY_INIT          = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic [7:0] pll_dynamicdelay,
    input  logic       delay_valid,
    input  logic [7:0] delay_data,
    output logic       delay_ready,
    output logic       clk_ready,
    output logic       fault,
    output logic [2:0] retry_count
);

    localparam int CYC_MAX = max2(RESET_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CYC_W   = cnt_width(CYC_MAX);
    localparam int TO_W    = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [CYC_W-1:0]   CYC_TOP     = CYC_W'(CYC_MAX);
    localparam logic [CYC_W-1:0]   RESET_LAST  = CYC_W'(RESET_CYCLES);
    localparam logic [CYC_W-1:0]   STABLE_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_TOP      = TO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_ctrl_state_t    state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d, cyc_inc;
    logic [TO_W-1:0]    to_q, to_d, to_inc;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               retry_go;
    logic               lock_s;

    pll_lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pll_lock),
        .sync_o  (lock_s)
    );

    // Saturating increments; counters never wrap.
    assign cyc_inc = (cyc_q == CYC_TOP) ? cyc_q : cyc_q + 1'b1;
    assign to_inc  = (to_q == TO_TOP) ? to_q : to_q + 1'b1;

`ifdef PLL_CTRL_DYNDELAY_EN
    logic [7:0] dly_q, dly_d;
`else
    // Delay inputs have no function without the dynamic-delay feature.
    logic unused_dly_inputs;
    assign unused_dly_inputs = &{1'b0, delay_valid, delay_data};
`endif

    // State, counters, retry count and delay register.
    // NOTE: the whole control state is cleared by rst, so the PLL is re-held in reset immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            to_q    <= '0;
            retry_q <= '0;
`ifdef PLL_CTRL_DYNDELAY_EN
            dly_q   <= DELAY_INIT;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
            retry_q <= retry_d;
`ifdef PLL_CTRL_DYNDELAY_EN
            dly_q   <= dly_d;
`endif
        end
    end

    // Next-state, counter and retry decisions.
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        to_d     = to_q;
        retry_d  = retry_q;
        retry_go = 1'b0;
`ifdef PLL_CTRL_DYNDELAY_EN
        dly_d    = dly_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cyc_d   = '0;
                to_d    = '0;
                retry_d = '0;
`ifdef PLL_CTRL_DYNDELAY_EN
                dly_d   = DELAY_INIT;
`endif
                if (enable) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (cyc_q == RESET_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    to_d    = '0;
                end else begin
                    cyc_d = cyc_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cyc_d   = '0;
                end else if (to_q == TO_LAST) begin
                    retry_go = 1'b1;
                end else begin
                    to_d = to_inc;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    to_d    = '0;
                end else if (cyc_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cyc_d = cyc_inc;
                end
            end
            ST_RUN: begin
                // Lock loss wins over a same-cycle delay handshake.
                if (!lock_s) begin
                    retry_go = 1'b1;
`ifdef PLL_CTRL_DYNDELAY_EN
                end else if (delay_valid) begin
                    dly_d   = delay_data;
                    state_d = ST_SETTLE;
                    cyc_d   = '0;
`endif
                end
            end
`ifdef PLL_CTRL_DYNDELAY_EN
            ST_SETTLE: begin
                if (!lock_s) begin
                    retry_go = 1'b1;
                end else if (cyc_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cyc_d = cyc_inc;
                end
            end
`endif
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retry_go) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_RESET;
                cyc_d   = '0;
                to_d    = '0;
            end else begin
                state_d = ST_FAULT;
            end
        end

        // Dropping enable returns straight to IDLE with IDLE's register values.
        if (!enable) begin
            state_d = ST_IDLE;
            cyc_d   = '0;
            to_d    = '0;
            retry_d = '0;
`ifdef PLL_CTRL_DYNDELAY_EN
            dly_d   = DELAY_INIT;
`endif
        end
    end

    // Outputs decode the state register only; no input reaches an output combinationally.
    assign pll_resetb  = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE) ||
                         (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign pll_bypass  = (state_q == ST_FAULT);
    assign fault       = (state_q == ST_FAULT);
    assign clk_ready   = (state_q == ST_RUN);
    assign retry_count = retry_q;

`ifdef PLL_CTRL_DYNDELAY_EN
    assign delay_ready      = (state_q == ST_RUN);
    assign pll_dynamicdelay = dly_q;
`else
    assign delay_ready      = 1'b0;
    assign pll_dynamicdelay = DELAY_INIT;
`endif

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed self-checking bench for pll_ctrl (short parameters).
// Edge numbers in comments count rising edges from the edge that samples enable=1.
module tb_pll_ctrl;

    localparam int         RC   = 4;
    localparam int         LSC  = 8;
    localparam int         LTC  = 32;
    localparam int         MR   = 2;
    localparam logic [7:0] DINIT = 8'hA5;

`ifdef PLL_CTRL_DYNDELAY_EN
    localparam logic       DR_RUN   = 1'b1;
    localparam logic [7:0] DLY_UPD  = 8'h5A;
`else
    localparam logic       DR_RUN   = 1'b0;
    localparam logic [7:0] DLY_UPD  = DINIT;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pll_lock = 1'b0;
    logic       delay_valid = 1'b0;
    logic [7:0] delay_data = 8'h00;
    logic       pll_resetb, pll_bypass, delay_ready, clk_ready, fault;
    logic [7:0] pll_dynamicdelay;
    logic [2:0] retry_count;

    int checks = 0;
    int errors = 0;

    pll_ctrl #(
        .RESET_CYCLES        (RC),
        .LOCK_STABLE_CYCLES  (LSC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .MAX_RETRIES         (MR),
        .DELAY_INIT          (DINIT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .pll_lock         (pll_lock),
        .pll_resetb       (pll_resetb),
        .pll_bypass       (pll_bypass),
        .pll_dynamicdelay (pll_dynamicdelay),
        .delay_valid      (delay_valid),
        .delay_data       (delay_data),
        .delay_ready      (delay_ready),
        .clk_ready        (clk_ready),
        .fault            (fault),
        .retry_count      (retry_count)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and stop at the following falling edge.
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic to_idle();
        enable      = 1'b0;
        pll_lock    = 1'b0;
        delay_valid = 1'b0;
        edges(3);
        checks++; if (retry_count !== 3'd0) begin errors++; $display("FAIL idle_retry: got %0d want 0", retry_count); end
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL idle_resetb: got %b want 0", pll_resetb); end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL rst_resetb: got %b want 0", pll_resetb); end
        checks++; if (pll_bypass !== 1'b0) begin errors++; $display("FAIL rst_bypass: got %b want 0", pll_bypass); end
        checks++; if (pll_dynamicdelay !== DINIT) begin errors++; $display("FAIL rst_dly: got %h want %h", pll_dynamicdelay, DINIT); end
        checks++; if ({delay_ready, clk_ready, fault} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {delay_ready, clk_ready, fault}); end
        checks++; if (retry_count !== 3'd0) begin errors++; $display("FAIL rst_retry: got %0d want 0", retry_count); end
        @(negedge clk);
        rst = 1'b0;
        edges(2);
    endtask

    // Ends in RUN, just after edge 20.
    task automatic test_nominal();
        enable = 1'b1;                 // sampled at edge 0
        edges(5);                      // after edge 4
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL nom_resetb_e4: got %b want 0", pll_resetb); end
        edges(1);                      // after edge 5
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL nom_resetb_e5: got %b want 1", pll_resetb); end
        edges(4);                      // after edge 9
        pll_lock = 1'b1;               // first sampled at edge 10
        edges(10);                     // after edge 19
        checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL nom_ready_e19: got %b want 0", clk_ready); end
        edges(1);                      // after edge 20
        checks++; if (clk_ready !== 1'b1) begin errors++; $display("FAIL nom_ready_e20: got %b want 1", clk_ready); end
        checks++; if (retry_count !== 3'd0) begin errors++; $display("FAIL nom_retry: got %0d want 0", retry_count); end
        checks++; if (delay_ready !== DR_RUN) begin errors++; $display("FAIL nom_dready: got %b want %b", delay_ready, DR_RUN); end
        checks++; if (pll_dynamicdelay !== DINIT) begin errors++; $display("FAIL nom_dly: got %h want %h", pll_dynamicdelay, DINIT); end
    endtask

    // Starts and ends in RUN.
    task automatic test_delay_update();
        delay_valid = 1'b1;
        delay_data  = 8'h5A;
        edges(1);                      // handshake edge h
        delay_valid = 1'b0;
        checks++; if (pll_dynamicdelay !== DLY_UPD) begin errors++; $display("FAIL dly_value: got %h want %h", pll_dynamicdelay, DLY_UPD); end
        checks++; if (delay_ready !== 1'b0) begin errors++; $display("FAIL dly_dready_h: got %b want 0", delay_ready); end
`ifdef PLL_CTRL_DYNDELAY_EN
        checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL dly_ready_h: got %b want 0", clk_ready); end
        edges(7);                      // h+7: last settle cycle
        checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL dly_ready_h7: got %b want 0", clk_ready); end
        edges(1);                      // h+8
        checks++; if (clk_ready !== 1'b1) begin errors++; $display("FAIL dly_ready_h8: got %b want 1", clk_ready); end
`else
        checks++; if (clk_ready !== 1'b1) begin errors++; $display("FAIL dly_ignored_ready: got %b want 1", clk_ready); end
        edges(8);
        checks++; if (pll_dynamicdelay !== DINIT) begin errors++; $display("FAIL dly_const: got %h want %h", pll_dynamicdelay, DINIT); end
        checks++; if (delay_ready !== 1'b0) begin errors++; $display("FAIL dly_dready_const: got %b want 0", delay_ready); end
`endif
    endtask

    // Starts in RUN; lock falls before edge k, handshake offered at edge k+2.
    task automatic test_lock_loss();
        pll_lock = 1'b0;
        edges(2);                      // after k+1
        checks++; if (clk_ready !== 1'b1) begin errors++; $display("FAIL loss_ready_k1: got %b want 1", clk_ready); end
        delay_valid = 1'b1;
        delay_data  = 8'hC3;
        edges(1);                      // after k+2
        delay_valid = 1'b0;
        checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL loss_ready_k2: got %b want 0", clk_ready); end
        checks++; if (retry_count !== 3'd1) begin errors++; $display("FAIL loss_retry: got %0d want 1", retry_count); end
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL loss_resetb: got %b want 0", pll_resetb); end
        checks++; if (pll_dynamicdelay !== DLY_UPD) begin errors++; $display("FAIL loss_hs_refused: got %h want %h", pll_dynamicdelay, DLY_UPD); end
    endtask

    // Starts in RESET with retry_count=1; pulses rst inside WAIT_LOCK.
    task automatic test_async_reset();
        edges(7);
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL arst_in_wait: got %b want 1", pll_resetb); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL arst_resetb: got %b want 0", pll_resetb); end
        checks++; if (retry_count !== 3'd0) begin errors++; $display("FAIL arst_retry: got %0d want 0", retry_count); end
        checks++; if (pll_dynamicdelay !== DINIT) begin errors++; $display("FAIL arst_dly: got %h want %h", pll_dynamicdelay, DINIT); end
        checks++; if ({pll_bypass, delay_ready, clk_ready, fault} !== 4'b0000) begin errors++; $display("FAIL arst_flags: got %b want 0000", {pll_bypass, delay_ready, clk_ready, fault}); end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout_fault();
        to_idle();
        enable = 1'b1;                 // edge 0
        edges(37);                     // after edge 36
        checks++; if (retry_count !== 3'd0 || pll_resetb !== 1'b1) begin errors++; $display("FAIL to_e36: got retry %0d resetb %b want 0 1", retry_count, pll_resetb); end
        edges(1);                      // after edge 37
        checks++; if (retry_count !== 3'd1 || pll_resetb !== 1'b0) begin errors++; $display("FAIL to_e37: got retry %0d resetb %b want 1 0", retry_count, pll_resetb); end
        edges(37);                     // after edge 74
        checks++; if (retry_count !== 3'd2) begin errors++; $display("FAIL to_e74: got retry %0d want 2", retry_count); end
        edges(36);                     // after edge 110
        checks++; if (fault !== 1'b0 || pll_resetb !== 1'b1) begin errors++; $display("FAIL to_e110: got fault %b resetb %b want 0 1", fault, pll_resetb); end
        edges(1);                      // after edge 111
        checks++; if ({fault, pll_bypass, pll_resetb, clk_ready} !== 4'b1100) begin errors++; $display("FAIL to_fault: got %b want 1100", {fault, pll_bypass, pll_resetb, clk_ready}); end
        checks++; if (retry_count !== 3'd2) begin errors++; $display("FAIL to_fault_retry: got %0d want 2", retry_count); end
        pll_lock = 1'b1;               // lock must not pull it out of FAULT
        edges(20);
        checks++; if (fault !== 1'b1 || pll_bypass !== 1'b1) begin errors++; $display("FAIL to_fault_hold: got %b%b want 11", fault, pll_bypass); end
        enable = 1'b0;
        edges(1);
        checks++; if ({fault, pll_bypass} !== 2'b00 || retry_count !== 3'd0) begin errors++; $display("FAIL to_exit: got %b%b retry %0d want 00 0", fault, pll_bypass, retry_count); end
    endtask

    task automatic test_stable_glitch();
        to_idle();
        enable = 1'b1;                 // edge 0
        edges(10);                     // after edge 9
        pll_lock = 1'b1;               // sampled at edge 10, STABLE from edge 12
        edges(5);                      // after edge 14
        pll_lock = 1'b0;               // low only at edge 15
        edges(1);
        pll_lock = 1'b1;
        edges(2);                      // after edge 17: back in WAIT_LOCK
        checks++; if (pll_resetb !== 1'b1 || clk_ready !== 1'b0) begin errors++; $display("FAIL gl_e17: got resetb %b ready %b want 1 0", pll_resetb, clk_ready); end
        edges(3);                      // after edge 20
        checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL gl_e20: got %b want 0", clk_ready); end
        edges(5);                      // after edge 25
        checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL gl_e25: got %b want 0", clk_ready); end
        edges(1);                      // after edge 26
        checks++; if (clk_ready !== 1'b1) begin errors++; $display("FAIL gl_e26: got %b want 1", clk_ready); end
        checks++; if (retry_count !== 3'd0) begin errors++; $display("FAIL gl_retry: got %0d want 0", retry_count); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_delay_update();
        test_lock_loss();
        test_async_reset();
        test_timeout_fault();
        test_stable_glitch();
        to_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
